q15_multiplier: RTL and testbench

//  Sequential signed fixed-point multiplier for the Q15.48 64-bit format (1 sign, 15 int, 48 frac).

---
 rtl/q15_multiplier_if.sv | 14 +
 rtl/q15_multiplier.sv | 124 ++++++++++++
 tb/tb_q15_multiplier.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/q15_multiplier_if.sv
// Launch/busy handshake bundle shared by the Q15.48 multiplier and its scheduler.
// The master issues an operation; the slave (arithmetic unit) reports busy and the result.
interface q15_multiplier_if #(
  parameter int WIDTH = 64
);
  logic             launch;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] res;

  modport master (output launch, a, b, input  busy, res);
  modport slave  (input  launch, a, b, output busy, res);
endinterface

// File: rtl/q15_multiplier.sv
// Sequential signed Q15.48 multiplier: shift-add over |a|*|b|, BITS_PER_CYCLE bits per cycle.
// Special operands (NaN, +/-inf, zero) resolve in one cycle without entering RUN.
module q15_multiplier #(
  parameter int WIDTH          = 64,
  parameter int FRAC_BITS      = 48,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  q15_multiplier_if.slave   bus
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int AW    = 2 * WIDTH;

  localparam logic [WIDTH-1:0] NAN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PINF_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NINF_VAL = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    SAT_LIM  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic             busy_q;
  logic [WIDTH-1:0] res_q;
  logic [AW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]    acc;
  logic             sign_q;
  logic [CNT_W-1:0] cnt;

  // Operand classification, evaluated combinationally on the launch cycle
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_sign;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_nan   = (bus.a == NAN_VAL);
  assign b_nan   = (bus.b == NAN_VAL);
  assign a_inf   = (bus.a == PINF_VAL) || (bus.a == NINF_VAL);
  assign b_inf   = (bus.b == PINF_VAL) || (bus.b == NINF_VAL);
  assign a_zero  = (bus.a == '0);
  assign b_zero  = (bus.b == '0);
  assign op_sign = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
  // NaN is excluded before RUN, so every magnitude here fits in WIDTH-1 bits
  assign a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;

  logic [AW-1:0]    partial;
  logic [AW-1:0]    acc_next;
  logic [AW-1:0]    m;
  logic [WIDTH-1:0] m_lo;
  logic [WIDTH-1:0] final_res;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
    acc_next = acc + partial;
    m        = acc_next >> FRAC_BITS;
    m_lo     = m[WIDTH-1:0];
    if (m >= SAT_LIM) final_res = sign_q ? NINF_VAL : PINF_VAL;
    else              final_res = sign_q ? -m_lo : m_lo;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, because an aborted operation must leave
      // no residue visible after release.
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      res_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.launch) begin
            if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
              res_q <= NAN_VAL;
            end else if (a_inf || b_inf) begin
              res_q <= op_sign ? NINF_VAL : PINF_VAL;
            end else if (a_zero || b_zero) begin
              res_q <= '0;
            end else begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              acc    <= '0;
              sign_q <= op_sign;
              cnt    <= '0;
              res_q  <= '0;
              busy_q <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            busy_q <= 1'b0;
            res_q  <= final_res;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.res  = res_q;

endmodule

// File: tb/tb_q15_multiplier.sv
// Self-checking bench for q15_multiplier: two instances (1 and 4 bits per cycle) run the same
// directed and random operations against a 128-bit arithmetic reference model.
module tb_q15_multiplier;

  localparam logic [63:0] NAN_V  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PINF_V = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NINF_V = 64'h8000_0000_0000_0001;
  localparam logic [63:0] ONE    = 64'h0001_0000_0000_0000;
  localparam logic [63:0] TWO    = 64'h0002_0000_0000_0000;
  localparam logic [63:0] THREE  = 64'h0003_0000_0000_0000;
  localparam logic [63:0] ONE_P5 = 64'h0001_8000_0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  q15_multiplier_if #(.WIDTH(64)) bus1 ();
  q15_multiplier_if #(.WIDTH(64)) bus4 ();

  q15_multiplier #(.WIDTH(64), .FRAC_BITS(48), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  q15_multiplier #(.WIDTH(64), .FRAC_BITS(48), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic l);
    bus1.a = a; bus1.b = b; bus1.launch = l;
    bus4.a = a; bus4.b = b; bus4.launch = l;
  endtask

  // Reference: classify specials, otherwise exact |a|*|b| in 128 bits, shift, saturate.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        output bit normal);
    logic          a_inf, b_inf, sgn;
    logic [63:0]   aa, bb;
    logic [127:0]  prod, mag;
    normal = 1'b0;
    a_inf  = (a == PINF_V) || (a == NINF_V);
    b_inf  = (b == PINF_V) || (b == NINF_V);
    sgn    = a[63] ^ b[63];
    if (a == NAN_V || b == NAN_V || (a_inf && b == 0) || (b_inf && a == 0)) return NAN_V;
    if (a_inf || b_inf) return sgn ? NINF_V : PINF_V;
    if (a == 0 || b == 0) return 64'd0;
    normal = 1'b1;
    aa   = a[63] ? -a : a;
    bb   = b[63] ? -b : b;
    prod = {64'd0, aa} * {64'd0, bb};
    mag  = prod >> 48;
    if (mag >= 128'h7FFF_FFFF_FFFF_FFFF) return sgn ? NINF_V : PINF_V;
    return sgn ? -mag[63:0] : mag[63:0];
  endfunction

  // Launch one op on both units, optionally pulse a second launch mid-run, and check
  // busy duration, res==0 during RUN and the final result.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit normal, input int pulse_at);
    int  n1, n4;
    bit  zero_ok;
    n1 = 0; n4 = 0; zero_ok = 1'b1;
    @(negedge clk);
    drive(a, b, 1'b1);
    @(negedge clk);
    drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (!bus1.busy && !bus4.busy) break;
      if (bus1.busy) begin n1++; if (bus1.res !== 64'd0) zero_ok = 1'b0; end
      if (bus4.busy) begin n4++; if (bus4.res !== 64'd0) zero_ok = 1'b0; end
      if (i == pulse_at) drive(THREE, THREE, 1'b1);
      else               drive(bus1.a, bus1.b, 1'b0);
      @(negedge clk);
    end
    drive(bus1.a, bus1.b, 1'b0);
    check({tag, " busy_cycles_bpc1"}, 64'(n1), normal ? 64'd64 : 64'd0);
    check({tag, " busy_cycles_bpc4"}, 64'(n4), normal ? 64'd16 : 64'd0);
    check({tag, " res_bpc1"}, bus1.res, exp);
    check({tag, " res_bpc4"}, bus4.res, exp);
    if (normal) check({tag, " res_zero_during_run"}, {63'd0, zero_ok}, 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb, rexp;
    logic [63:0] specials [6];
    bit          rnorm;
    specials = '{NAN_V, PINF_V, NINF_V, 64'd0, ONE, 64'hFFFF_0000_0000_0000};

    reset = 1'b1;
    drive(64'd0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, bus1.busy}, 64'd0);
    check("reset res",  bus1.res, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations
    run_op("1.5x2.0",   ONE_P5, TWO, THREE, 1'b1, -1);
    run_op("-1.5x2.0",  64'hFFFE_8000_0000_0000, TWO, 64'hFFFD_0000_0000_0000, 1'b1, -1);
    run_op("0.5^2",     64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000,
                        64'h0000_4000_0000_0000, 1'b1, -1);
    run_op("ovf_pos",   64'h4000_0000_0000_0000, 64'h0004_0000_0000_0000, PINF_V, 1'b1, -1);
    run_op("ovf_neg",   64'h4000_0000_0000_0000, 64'hFFFC_0000_0000_0000, NINF_V, 1'b1, -1);
    run_op("underflow", 64'd1, 64'd1, 64'd0, 1'b1, -1);
    run_op("neg_uflow", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, -1);
    run_op("inf*0",     PINF_V, 64'd0, NAN_V, 1'b0, -1);
    run_op("nan*1",     NAN_V, ONE, NAN_V, 1'b0, -1);
    run_op("-inf*2",    NINF_V, TWO, NINF_V, 1'b0, -1);
    run_op("0*-3",      64'd0, 64'hFFFD_0000_0000_0000, 64'd0, 1'b0, -1);
    run_op("launch_ignored", ONE_P5, TWO, THREE, 1'b1, 10);

    // Reset in the middle of RUN aborts the operation
    @(negedge clk);
    drive(ONE_P5, TWO, 1'b1);
    @(negedge clk);
    drive(ONE_P5, TWO, 1'b0);
    repeat (19) @(negedge clk);
    check("mid_run busy", {63'd0, bus1.busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("abort busy", {63'd0, bus1.busy}, 64'd0);
    check("abort res",  bus1.res, 64'd0);
    check("abort res4", bus4.res, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    check("post_abort busy", {63'd0, bus1.busy}, 64'd0);
    check("post_abort res",  bus1.res, 64'd0);

    // Random operands, scaled so products land across the finite range, with specials mixed in
    for (int k = 0; k < 24; k++) begin
      ra = 64'($signed({$urandom, $urandom}) >>> $urandom_range(0, 40));
      rb = 64'($signed({$urandom, $urandom}) >>> $urandom_range(8, 48));
      if ($urandom_range(0, 5) == 0) ra = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) rb = specials[$urandom_range(0, 5)];
      rexp = model(ra, rb, rnorm);
      run_op($sformatf("rand%0d", k), ra, rb, rexp, rnorm, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
